// File: rtl/rvfi_multi_reg_check_pkg.sv
// Shared definitions for the rvfi_* trace checkers.
// Register address width and index-width helper.
package rvfi_multi_reg_check_pkg;

   localparam int REG_AW = 5;

   function automatic int idx_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n)
         w++;
      return w;
   endfunction

endpackage

// File: rtl/rvfi_multi_reg_check_if.sv
// RVFI retirement trace bundle, NRET channels wide.
// The core side drives it, checkers listen.
interface rvfi_multi_reg_check_if
   import rvfi_multi_reg_check_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NRET    = 1,
   parameter int ORDER_W = 64
);

   logic [NRET-1:0]         rvfi_valid;
   logic [NRET*ORDER_W-1:0] rvfi_order;
   logic [NRET*REG_AW-1:0]  rvfi_rs1_addr;
   logic [NRET*REG_AW-1:0]  rvfi_rs2_addr;
   logic [NRET*REG_AW-1:0]  rvfi_rd_addr;
   logic [NRET*XLEN-1:0]    rvfi_rs1_rdata;
   logic [NRET*XLEN-1:0]    rvfi_rs2_rdata;
   logic [NRET*XLEN-1:0]    rvfi_rd_wdata;

   modport master (
      output rvfi_valid, rvfi_order,
      output rvfi_rs1_addr, rvfi_rs2_addr,
      output rvfi_rd_addr,
      output rvfi_rs1_rdata, rvfi_rs2_rdata,
      output rvfi_rd_wdata
   );

   modport slave (
      input rvfi_valid, rvfi_order,
      input rvfi_rs1_addr, rvfi_rs2_addr,
      input rvfi_rd_addr,
      input rvfi_rs1_rdata, rvfi_rs2_rdata,
      input rvfi_rd_wdata
   );

endinterface

// File: rtl/rvfi_reg_shadow_slot.sv
// Shadow of one tracked architectural register.
// Walks the channels in order: check reads, then apply the write.
module rvfi_reg_shadow_slot
   import rvfi_multi_reg_check_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NRET      = 1,
   parameter bit ZERO_INIT = 1'b0
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [REG_AW-1:0]      reg_idx,
   input  logic [NRET-1:0]        valid,
   input  logic [NRET*REG_AW-1:0] rs1_addr,
   input  logic [NRET*REG_AW-1:0] rs2_addr,
   input  logic [NRET*REG_AW-1:0] rd_addr,
   input  logic [NRET*XLEN-1:0]   rs1_rdata,
   input  logic [NRET*XLEN-1:0]   rs2_rdata,
   input  logic [NRET*XLEN-1:0]   rd_wdata,
   output logic                   written,
   output logic [NRET-1:0]        mism
);

   logic [XLEN-1:0] shadow_q;
   logic [XLEN-1:0] shadow_d;
   logic            written_q;
   logic            written_d;

   logic [REG_AW-1:0] a1;
   logic [REG_AW-1:0] a2;
   logic [REG_AW-1:0] ad;

   // shadow_d/written_d carry lower-channel writes up the chain
   always_comb begin
      shadow_d  = shadow_q;
      written_d = written_q;
      mism      = '0;
      a1        = '0;
      a2        = '0;
      ad        = '0;
      for (int c = 0; c < NRET; c++) begin
         a1 = rs1_addr[c*REG_AW +: REG_AW];
         a2 = rs2_addr[c*REG_AW +: REG_AW];
         ad = rd_addr[c*REG_AW +: REG_AW];
         if (valid[c]) begin
            if (written_d && a1 == reg_idx &&
                shadow_d != rs1_rdata[c*XLEN +: XLEN])
               mism[c] = 1'b1;
            if (written_d && a2 == reg_idx &&
                shadow_d != rs2_rdata[c*XLEN +: XLEN])
               mism[c] = 1'b1;
            if (reg_idx != '0 && ad == reg_idx) begin
               shadow_d  = rd_wdata[c*XLEN +: XLEN];
               written_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         shadow_q  <= '0;
         written_q <= ZERO_INIT | (reg_idx == '0);
      end else begin
         shadow_q  <= shadow_d;
         written_q <= written_d;
      end
   end

   assign written = written_q;

endmodule

// File: rtl/rvfi_multi_reg_check.sv
// Register-file consistency checker on the RVFI trace.
// Sticky error flags plus first-failure channel/slot.
module rvfi_multi_reg_check
   import rvfi_multi_reg_check_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int NRET        = 1,
   parameter int NREGS       = 2,
   parameter int ORDER_W     = 64,
   parameter int ZERO_INIT   = 0,
   parameter int X0_CHECK    = 1,
   parameter int ORDER_CHECK = 1,
   localparam int CW         = idx_w(NRET),
   localparam int SW         = idx_w(NREGS)
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [NREGS*REG_AW-1:0] reg_index,
   rvfi_multi_reg_check_if.slave   rvfi,
   output logic [NREGS-1:0]        written,
   output logic                    err_rs,
   output logic                    err_x0,
   output logic                    err_order,
   output logic                    err_any,
   output logic [CW-1:0]           fail_chan,
   output logic [SW-1:0]           fail_slot
);

   logic [NRET-1:0] mism [NREGS];

   for (genvar k = 0; k < NREGS; k++) begin : g_slot
      rvfi_reg_shadow_slot #(
         .XLEN      (XLEN),
         .NRET      (NRET),
         .ZERO_INIT (ZERO_INIT != 0)
      ) u_slot (
         .clk       (clk),
         .resetn    (resetn),
         .reg_idx   (reg_index[k*REG_AW +: REG_AW]),
         .valid     (rvfi.rvfi_valid),
         .rs1_addr  (rvfi.rvfi_rs1_addr),
         .rs2_addr  (rvfi.rvfi_rs2_addr),
         .rd_addr   (rvfi.rvfi_rd_addr),
         .rs1_rdata (rvfi.rvfi_rs1_rdata),
         .rs2_rdata (rvfi.rvfi_rs2_rdata),
         .rd_wdata  (rvfi.rvfi_rd_wdata),
         .written   (written[k]),
         .mism      (mism[k])
      );
   end

   logic [ORDER_W-1:0] exp_q;
   logic [ORDER_W-1:0] exp_d;
   logic               seen_q;
   logic               seen_d;
   logic [ORDER_W-1:0] ord;
   logic [NRET-1:0]    rs_hit;
   logic [NRET-1:0]    x0_hit;
   logic [NRET-1:0]    ord_hit;

   always_comb begin
      exp_d   = exp_q;
      seen_d  = seen_q;
      ord     = '0;
      rs_hit  = '0;
      x0_hit  = '0;
      ord_hit = '0;
      for (int c = 0; c < NRET; c++) begin
         ord = rvfi.rvfi_order[c*ORDER_W +: ORDER_W];
         if (rvfi.rvfi_valid[c]) begin
            for (int k = 0; k < NREGS; k++)
               if (mism[k][c])
                  rs_hit[c] = 1'b1;
            if (X0_CHECK != 0) begin
               if (rvfi.rvfi_rs1_addr[c*REG_AW +: REG_AW] == '0 &&
                   rvfi.rvfi_rs1_rdata[c*XLEN +: XLEN] != '0)
                  x0_hit[c] = 1'b1;
               if (rvfi.rvfi_rs2_addr[c*REG_AW +: REG_AW] == '0 &&
                   rvfi.rvfi_rs2_rdata[c*XLEN +: XLEN] != '0)
                  x0_hit[c] = 1'b1;
               if (rvfi.rvfi_rd_addr[c*REG_AW +: REG_AW] == '0 &&
                   rvfi.rvfi_rd_wdata[c*XLEN +: XLEN] != '0)
                  x0_hit[c] = 1'b1;
            end
            if (ORDER_CHECK != 0 && seen_d && ord != exp_d)
               ord_hit[c] = 1'b1;
            exp_d  = ord + ORDER_W'(1);
            seen_d = 1'b1;
         end
      end
   end

   logic          found;
   logic [CW-1:0] f_chan;
   logic [SW-1:0] f_slot;

   // lowest failing channel; within it the lowest mismatching slot
   always_comb begin
      found  = 1'b0;
      f_chan = '0;
      f_slot = '0;
      for (int c = 0; c < NRET; c++) begin
         if (!found && (rs_hit[c] | x0_hit[c] | ord_hit[c])) begin
            found  = 1'b1;
            f_chan = CW'(c);
            for (int k = NREGS - 1; k >= 0; k--)
               if (mism[k][c])
                  f_slot = SW'(k);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         exp_q     <= '0;
         seen_q    <= 1'b0;
         err_rs    <= 1'b0;
         err_x0    <= 1'b0;
         err_order <= 1'b0;
         fail_chan <= '0;
         fail_slot <= '0;
      end else begin
         exp_q     <= exp_d;
         seen_q    <= seen_d;
         err_rs    <= err_rs | (|rs_hit);
         err_x0    <= err_x0 | (|x0_hit);
         err_order <= err_order | (|ord_hit);
         if (found && !err_any) begin
            fail_chan <= f_chan;
            fail_slot <= f_slot;
         end
      end
   end

   assign err_any = err_rs | err_x0 | err_order;

`ifdef FORMAL
   always_comb begin
      if (resetn) begin
         a_rs    : assert (rs_hit == '0);
         a_x0    : assert (x0_hit == '0);
         a_order : assert (ord_hit == '0);
      end
   end
`endif

endmodule
